// File: rtl/fetch_sequencer_if.sv
// Handshake bundle between the fetch sequencer and the datapath / execute unit.
// STEP exists only when FETCH_STEP_EN is defined.
interface fetch_sequencer_if;
`ifdef FETCH_STEP_EN
  logic       STEP;
`endif
  logic       RUN;
  logic       MEM_ACK;
  logic       EXEC_DONE;
  logic       BRANCH_TAKEN;
  logic       HALT;
  logic       PC_LOAD;
  logic       PC_INC;
  logic       AR_LOAD;
  logic       IR_LOAD;
  logic [1:0] BUS_SEL;
  logic       MEM_REQ;
  logic       EXEC_START;
  logic       BUSY;
  logic       FAULT;
  logic [2:0] STATE;

  modport master (
`ifdef FETCH_STEP_EN
    input  STEP,
`endif
    input  RUN,
    input  MEM_ACK,
    input  EXEC_DONE,
    input  BRANCH_TAKEN,
    input  HALT,
    output PC_LOAD,
    output PC_INC,
    output AR_LOAD,
    output IR_LOAD,
    output BUS_SEL,
    output MEM_REQ,
    output EXEC_START,
    output BUSY,
    output FAULT,
    output STATE
  );

  modport slave (
`ifdef FETCH_STEP_EN
    output STEP,
`endif
    output RUN,
    output MEM_ACK,
    output EXEC_DONE,
    output BRANCH_TAKEN,
    output HALT,
    input  PC_LOAD,
    input  PC_INC,
    input  AR_LOAD,
    input  IR_LOAD,
    input  BUS_SEL,
    input  MEM_REQ,
    input  EXEC_START,
    input  BUSY,
    input  FAULT,
    input  STATE
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-cycle controller for the 16-bit accumulator CPU (Moore FSM).
// Define FETCH_STEP_EN to add single-step operation via the STEP input.
module fetch_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_BITS     = 4
) (
  input  logic CLOCK,
  input  logic RESET,
  fetch_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH_AR  = 3'd1,
    S_MEM_WAIT  = 3'd2,
    S_FETCH_IR  = 3'd3,
    S_EXEC_GO   = 3'd4,
    S_EXEC_WAIT = 3'd5,
    S_BRANCH    = 3'd6,
    S_FAULT     = 3'd7
  } state_e;

  localparam logic [TO_BITS-1:0] TO_LIMIT = TO_BITS'(MEM_TIMEOUT);

  state_e             state_q, state_d;
  logic [TO_BITS-1:0] to_q, to_d;
  logic               stop_q, stop_d;
  logic               start_ok;
  logic               step_mode;

`ifdef FETCH_STEP_EN
  assign start_ok  = bus.STEP;
  assign step_mode = 1'b1;
`else
  assign start_ok  = bus.RUN;
  assign step_mode = 1'b0;
`endif

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      to_q    <= '0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      to_q    <= to_d;
      stop_q  <= stop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    to_d    = '0;
    stop_d  = stop_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_ok) state_d = S_FETCH_AR;
      end
      S_FETCH_AR: state_d = S_MEM_WAIT;
      S_MEM_WAIT: begin
        to_d = to_q + TO_BITS'(1);
        // an ack arriving in the limit cycle still wins
        if (bus.MEM_ACK) begin
          state_d = S_FETCH_IR;
          to_d    = '0;
        end else if (MEM_TIMEOUT != 0 && to_d == TO_LIMIT) begin
          state_d = S_FAULT;
          to_d    = '0;
        end
      end
      S_FETCH_IR: state_d = S_EXEC_GO;
      S_EXEC_GO:  state_d = S_EXEC_WAIT;
      S_EXEC_WAIT: begin
        if (bus.EXEC_DONE) begin
          stop_d = bus.HALT | ~bus.RUN;
          if (bus.BRANCH_TAKEN)
            state_d = S_BRANCH;
          else if (step_mode | bus.HALT | ~bus.RUN)
            state_d = S_IDLE;
          else
            state_d = S_FETCH_AR;
        end
      end
      S_BRANCH: begin
        if (step_mode | stop_q) state_d = S_IDLE;
        else                    state_d = S_FETCH_AR;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.PC_LOAD    = 1'b0;
    bus.PC_INC     = 1'b0;
    bus.AR_LOAD    = 1'b0;
    bus.IR_LOAD    = 1'b0;
    bus.BUS_SEL    = 2'd0;
    bus.MEM_REQ    = 1'b0;
    bus.EXEC_START = 1'b0;
    bus.BUSY       = 1'b1;
    bus.FAULT      = 1'b0;
    unique case (state_q)
      S_IDLE: bus.BUSY = 1'b0;
      S_FETCH_AR: begin
        bus.AR_LOAD = 1'b1;
        bus.BUS_SEL = 2'd1;
      end
      S_MEM_WAIT: begin
        bus.MEM_REQ = 1'b1;
        bus.BUS_SEL = 2'd2;
      end
      S_FETCH_IR: begin
        bus.IR_LOAD = 1'b1;
        bus.BUS_SEL = 2'd2;
        bus.PC_INC  = 1'b1;
      end
      S_EXEC_GO:   bus.EXEC_START = 1'b1;
      S_EXEC_WAIT: ;
      S_BRANCH: begin
        bus.PC_LOAD = 1'b1;
        bus.BUS_SEL = 2'd3;
      end
      S_FAULT: begin
        bus.BUSY  = 1'b0;
        bus.FAULT = 1'b1;
      end
      default: bus.BUSY = 1'b0;
    endcase
  end

  assign bus.STATE = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer.
// Define FETCH_STEP_EN to exercise the single-step build.
module tb_fetch_sequencer;

  logic CLOCK = 1'b0;
  logic RESET;
  int   passed = 0;
  int   total  = 0;

  fetch_sequencer_if bus ();

  fetch_sequencer #(
    .MEM_TIMEOUT (15),
    .TO_BITS     (4)
  ) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus.master)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic wait_state(input int s);
    for (int i = 0; i < 20; i++) begin
      if (int'(bus.STATE) == s) break;
      step();
    end
    chk("reach_state", int'(bus.STATE), s);
  endtask

  task automatic chk_outs(input string tag, input int s);
    int sel;
    sel = (s == 1) ? 1 : (s == 2 || s == 3) ? 2 : (s == 6) ? 3 : 0;
    chk({tag, "_state"},  int'(bus.STATE),      s);
    chk({tag, "_arld"},   int'(bus.AR_LOAD),    int'(s == 1));
    chk({tag, "_memreq"}, int'(bus.MEM_REQ),    int'(s == 2));
    chk({tag, "_irld"},   int'(bus.IR_LOAD),    int'(s == 3));
    chk({tag, "_pcinc"},  int'(bus.PC_INC),     int'(s == 3));
    chk({tag, "_start"},  int'(bus.EXEC_START), int'(s == 4));
    chk({tag, "_pcld"},   int'(bus.PC_LOAD),    int'(s == 6));
    chk({tag, "_bussel"}, int'(bus.BUS_SEL),    sel);
    chk({tag, "_busy"},   int'(bus.BUSY),       int'(s != 0 && s != 7));
    chk({tag, "_fault"},  int'(bus.FAULT),      int'(s == 7));
  endtask

  initial begin
    int n;
    RESET            = 1'b1;
    bus.RUN          = 1'b0;
    bus.MEM_ACK      = 1'b0;
    bus.EXEC_DONE    = 1'b0;
    bus.BRANCH_TAKEN = 1'b0;
    bus.HALT         = 1'b0;
`ifdef FETCH_STEP_EN
    bus.STEP         = 1'b0;
`endif
    step();
    step();
    chk_outs("reset", 0);
    RESET = 1'b0;
    step();
    chk("idle_hold", int'(bus.STATE), 0);

`ifdef FETCH_STEP_EN
    bus.RUN       = 1'b1;
    bus.MEM_ACK   = 1'b1;
    bus.EXEC_DONE = 1'b1;
    step();
    step();
    chk("step_run_ignored", int'(bus.STATE), 0);
    bus.STEP = 1'b1;
    step();
    bus.STEP = 1'b0;
    chk("step_fetch_ar", int'(bus.STATE), 1);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      n += int'(bus.EXEC_START);
      step();
    end
    chk("step_one_start", n, 1);
    chk("step_back_idle", int'(bus.STATE), 0);
    bus.STEP         = 1'b1;
    bus.BRANCH_TAKEN = 1'b1;
    wait_state(6);
    bus.STEP         = 1'b0;
    bus.BRANCH_TAKEN = 1'b0;
    step();
    chk("step_branch_idle", int'(bus.STATE), 0);
`else
    bus.RUN       = 1'b1;
    bus.MEM_ACK   = 1'b1;
    bus.EXEC_DONE = 1'b1;
    step();
    n = 0;
    for (int i = 0; i < 10; i++) begin
      chk_outs("seq", (i % 5) + 1);
      n += int'(bus.PC_INC);
      step();
    end
    chk("pcinc_count", n, 2);

    wait_state(5);
    bus.BRANCH_TAKEN = 1'b1;
    step();
    chk_outs("branch", 6);
    bus.BRANCH_TAKEN = 1'b0;
    step();
    chk("branch_next", int'(bus.STATE), 1);

    wait_state(5);
    bus.HALT = 1'b1;
    step();
    chk("halt_idle", int'(bus.STATE), 0);
    bus.HALT = 1'b0;
    step();
    chk("restart", int'(bus.STATE), 1);

    wait_state(5);
    bus.BRANCH_TAKEN = 1'b1;
    bus.HALT         = 1'b1;
    step();
    chk("br_halt_branch", int'(bus.STATE), 6);
    bus.BRANCH_TAKEN = 1'b0;
    bus.HALT         = 1'b0;
    step();
    chk("br_halt_latched", int'(bus.STATE), 0);
    step();

    bus.EXEC_DONE = 1'b0;
    wait_state(5);
    step();
    step();
    chk("exec_wait_hold", int'(bus.STATE), 5);
    bus.EXEC_DONE = 1'b1;
    bus.RUN       = 1'b0;
    step();
    chk("run_low_idle", int'(bus.STATE), 0);

    bus.RUN = 1'b1;
    step();
    chk("run_restart", int'(bus.STATE), 1);
    bus.RUN = 1'b0;
    step();
    chk("run_drop_continue", int'(bus.STATE), 2);
    wait_state(5);
    step();
    chk("run_drop_idle", int'(bus.STATE), 0);

    bus.RUN     = 1'b1;
    bus.MEM_ACK = 1'b0;
    step();
    step();
    chk("ack15_enter", int'(bus.STATE), 2);
    for (int i = 0; i < 14; i++) step();
    chk("ack15_still_wait", int'(bus.STATE), 2);
    bus.MEM_ACK = 1'b1;
    step();
    chk("ack15_fetch_ir", int'(bus.STATE), 3);
    chk("ack15_no_fault", int'(bus.FAULT), 0);

    bus.MEM_ACK = 1'b0;
    wait_state(2);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (int'(bus.STATE) != 2) break;
      n += int'(bus.MEM_REQ);
      step();
    end
    chk("timeout_req_cycles", n, 15);
    chk_outs("fault", 7);
    bus.RUN     = 1'b0;
    step();
    bus.RUN     = 1'b1;
    bus.MEM_ACK = 1'b1;
    step();
    step();
    chk("fault_sticky", int'(bus.STATE), 7);

    #3 RESET = 1'b1;
    #1;
    chk("fault_async_reset", int'(bus.STATE), 0);
    step();
    RESET       = 1'b0;
    bus.MEM_ACK = 1'b0;
    wait_state(2);
    step();
    #3 RESET = 1'b1;
    #1;
    chk_outs("async_reset_memwait", 0);
    step();
    RESET = 1'b0;
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
